// File: rtl/vec_mem_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding and master ids.
package vec_mem_pkg;

  // Arbiter FSM states. IDLE is zero so a cleared state register means idle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Master ids; also the encoding of the grant and last-served registers.
  localparam logic M_CPU = 1'b0;
  localparam logic M_VEC = 1'b1;

endpackage

// File: rtl/vec_rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester wins, and on a tie
// the master that was not served last wins.
module vec_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       gnt_valid,
  output logic       gnt_id
);
  import vec_mem_pkg::*;

  // Pick a winner from the current requests and the last-served id.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = M_CPU;
    case (req)
      2'b01:   gnt_id = M_CPU;
      2'b10:   gnt_id = M_VEC;
      2'b11:   gnt_id = ~last_served;
      default: gnt_id = M_CPU;
    endcase
  end

endmodule

// File: rtl/vec_mem_arbiter.sv
// Two-master shared-memory arbiter: picorv32 native port (m0, cpu_*) and the
// vector coprocessor port (m1, vec_*) share one slave port, one transaction
// at a time, round-robin on contention, with an out-of-range address guard.
//
// Handshake (all ports): a master raises valid with stable addr/wdata/wstrb
// and holds it until its ready pulses for exactly one cycle; rdata is only
// meaningful while ready is high. The slave side follows the same rule with
// mem_valid held until mem_ready, and mem_rdata sampled with mem_ready.
module vec_mem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter bit          RESET_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_instr,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        proto_err,
  output logic [1:0]  dbg_state
);
  import vec_mem_pkg::*;

  state_t      state_q;
  state_t      state_d;
  logic        gnt_q;       // master owning the current transaction
  logic        last_q;      // master served most recently
  logic        drop_q;      // granted master abandoned its request in REQ
  logic [31:0] rdata_q;

  logic        arb_valid;
  logic        arb_id;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_instr;
  logic        in_range;
  logic        gnt_master_valid;

  vec_rr_arbiter2 u_arb (
    .req         ({vec_mem_valid, cpu_mem_valid}),
    .last_served (last_q),
    .gnt_valid   (arb_valid),
    .gnt_id      (arb_id)
  );

  // Request mux for the arbitration winner; the vector port never fetches.
  always_comb begin
    sel_addr  = cpu_mem_addr;
    sel_wdata = cpu_mem_wdata;
    sel_wstrb = cpu_mem_wstrb;
    sel_instr = cpu_mem_instr;
    if (arb_id == M_VEC) begin
      sel_addr  = vec_mem_addr;
      sel_wdata = vec_mem_wdata;
      sel_wstrb = vec_mem_wstrb;
      sel_instr = 1'b0;
    end
  end

  assign in_range         = (sel_addr < ADDR_LIMIT);
  assign gnt_master_valid = (gnt_q == M_CPU) ? cpu_mem_valid : vec_mem_valid;
  assign dbg_state        = state_q;

  // Next-state and master-side response outputs.
  always_comb begin
    state_d       = state_q;
    cpu_mem_ready = 1'b0;
    vec_mem_ready = 1'b0;
    cpu_mem_rdata = '0;
    vec_mem_rdata = '0;
    bus_err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) state_d = in_range ? REQ : ERR;
      end
      REQ: begin
        if (mem_ready) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        // A master that walked away gets no completion pulse.
        if (!drop_q) begin
          if (gnt_q == M_CPU) begin
            cpu_mem_ready = 1'b1;
            cpu_mem_rdata = rdata_q;
          end else begin
            vec_mem_ready = 1'b1;
            vec_mem_rdata = rdata_q;
          end
        end
      end
      ERR: begin
        state_d = IDLE;
        bus_err = 1'b1;
        if (gnt_q == M_CPU) cpu_mem_ready = 1'b1;
        else                vec_mem_ready = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and round-robin history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= RESET_LAST;
    end else begin
      state_q <= state_d;
      if ((state_q == REQ && mem_ready) || state_q == ERR) last_q <= gnt_q;
    end
  end

  // Request capture, slave request outputs, read data and protocol tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_q     <= M_CPU;
      drop_q    <= 1'b0;
      rdata_q   <= '0;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      proto_err <= 1'b0;
    end else begin
      mem_valid <= (state_d == REQ);
      if (state_q == IDLE && arb_valid) begin
        gnt_q     <= arb_id;
        drop_q    <= 1'b0;
        mem_instr <= sel_instr;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        mem_wstrb <= sel_wstrb;
      end
      if (state_q == REQ) begin
        // The slave access is never aborted; only the master response is dropped.
        if (!gnt_master_valid) begin
          drop_q    <= 1'b1;
          proto_err <= 1'b1;
        end
        if (mem_ready) rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Directed testbench for vec_mem_arbiter with a simple word-addressed memory slave.
module tb_vec_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        cpu_mem_valid;
  logic        cpu_mem_instr;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_ready;
  logic [31:0] cpu_mem_rdata;
  logic        vec_mem_valid;
  logic [31:0] vec_mem_addr;
  logic [31:0] vec_mem_wdata;
  logic [3:0]  vec_mem_wstrb;
  logic        vec_mem_ready;
  logic [31:0] vec_mem_rdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        proto_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int slave_delay = 1;
  logic [31:0] mem [0:255];
  logic [32:0] exp_q[$];

  // Observations gathered by the transfer driver.
  int          obs_lat;
  logic [31:0] obs_rd;
  bit          obs_other;
  bit          obs_mv;
  bit          obs_be;
  logic [31:0] obs_maddr;
  logic [31:0] obs_mwdata;
  logic [3:0]  obs_mwstrb;
  logic        obs_minstr;

  vec_mem_arbiter #(.ADDR_LIMIT(1024), .RESET_LAST(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready),
    .cpu_mem_rdata(cpu_mem_rdata),
    .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr),
    .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb),
    .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory slave: answers slave_delay cycles after mem_valid first appears,
  // returning the pre-write word and applying byte strobes.
  initial begin : slave
    int s_cnt;
    logic [7:0] widx;
    s_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (mem_valid) begin
        s_cnt++;
        if (s_cnt == slave_delay + 1) begin
          widx = mem_addr[9:2];
          mem_rdata = mem[widx];
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[widx][8*b +: 8] = mem_wdata[8*b +: 8];
          mem_ready = 1'b1;
          s_cnt = 0;
        end
      end else begin
        s_cnt = 0;
      end
    end
  end

  // Driver: reset pulse, ending on a negedge with the arbiter idle.
  task automatic apply_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Driver: one transfer from master m (0 cpu, 1 vec); call on a negedge with
  // the arbiter idle. Leaves one idle cycle after the ready pulse.
  task automatic xfer(input bit m, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic ins);
    obs_lat = -1; obs_rd = 'x; obs_other = 0; obs_mv = 0; obs_be = 0;
    obs_maddr = 'x; obs_mwdata = 'x; obs_mwstrb = 'x; obs_minstr = 1'bx;
    if (!m) begin
      cpu_mem_valid = 1'b1; cpu_mem_addr = a; cpu_mem_wdata = wd;
      cpu_mem_wstrb = ws; cpu_mem_instr = ins;
    end else begin
      vec_mem_valid = 1'b1; vec_mem_addr = a; vec_mem_wdata = wd;
      vec_mem_wstrb = ws;
    end
    for (int c = 1; c <= 20 && obs_lat < 0; c++) begin
      @(negedge clk);
      if (mem_valid && !obs_mv) begin
        obs_mv = 1; obs_maddr = mem_addr; obs_mwdata = mem_wdata;
        obs_mwstrb = mem_wstrb; obs_minstr = mem_instr;
      end
      if (bus_err) obs_be = 1;
      if (m ? cpu_mem_ready : vec_mem_ready) obs_other = 1;
      if (m ? vec_mem_ready : cpu_mem_ready) begin
        obs_lat = c;
        obs_rd  = m ? vec_mem_rdata : cpu_mem_rdata;
      end
    end
    if (!m) cpu_mem_valid = 1'b0;
    else    vec_mem_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cpu_mem_valid = 0; cpu_mem_instr = 0; cpu_mem_addr = 0; cpu_mem_wdata = 0; cpu_mem_wstrb = 0;
    vec_mem_valid = 0; vec_mem_addr = 0; vec_mem_wdata = 0; vec_mem_wstrb = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({cpu_mem_ready, cpu_mem_rdata, vec_mem_ready, vec_mem_rdata, mem_valid, mem_instr,
         mem_addr, mem_wdata, mem_wstrb, bus_err, proto_err, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got mem_valid=%b cpu_rdy=%b vec_rdy=%b addr=%h state=%0d, want all 0",
               mem_valid, cpu_mem_ready, vec_mem_ready, mem_addr, dbg_state);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    xfer(1'b0, 32'h190, 32'h0, 4'b0000, 1'b1);
    total++; if (obs_lat !== 3) begin bad++; $display("FAIL cpu_read_latency: got %0d want 3", obs_lat); end
    total++; if (obs_rd !== 32'h04030201) begin bad++; $display("FAIL cpu_read_rdata: got %h want 04030201", obs_rd); end
    total++; if (obs_other !== 1'b0) begin bad++; $display("FAIL cpu_read_vec_ready: got %b want 0", obs_other); end
    total++; if (obs_maddr !== 32'h190) begin bad++; $display("FAIL cpu_read_mem_addr: got %h want 00000190", obs_maddr); end
    total++; if (obs_minstr !== 1'b1) begin bad++; $display("FAIL cpu_read_mem_instr: got %b want 1", obs_minstr); end
    total++; if (cpu_mem_ready !== 1'b0) begin bad++; $display("FAIL cpu_read_ready_width: got %b want 0", cpu_mem_ready); end
  endtask

  task automatic test_contention();
    int cpu_first, vec_first, n_done;
    bit both;
    logic [32:0] e;
    apply_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 32'h11111111});
      exp_q.push_back({1'b1, 32'h04030201});
    end
    cpu_first = -1; vec_first = -1; n_done = 0; both = 0;
    cpu_mem_valid = 1; cpu_mem_addr = 32'h0;   cpu_mem_wstrb = 0; cpu_mem_instr = 0;
    vec_mem_valid = 1; vec_mem_addr = 32'h191; vec_mem_wstrb = 0;
    for (int cyc = 1; cyc <= 60 && n_done < 6; cyc++) begin
      @(negedge clk);
      if (cpu_mem_ready && vec_mem_ready) both = 1;
      if (cpu_mem_ready || vec_mem_ready) begin
        if (cpu_mem_ready && cpu_first < 0) cpu_first = cyc;
        if (vec_mem_ready && vec_first < 0) vec_first = cyc;
        n_done++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rr_order: unexpected extra completion");
        end else begin
          e = exp_q.pop_front();
          if ((vec_mem_ready ? {1'b1, vec_mem_rdata} : {1'b0, cpu_mem_rdata}) !== e) begin
            bad++;
            $display("FAIL rr_order: got id=%b cpu=%h vec=%h want id=%b data=%h",
                     vec_mem_ready, cpu_mem_rdata, vec_mem_rdata, e[32], e[31:0]);
          end
        end
      end
    end
    cpu_mem_valid = 0; vec_mem_valid = 0;
    @(negedge clk);
    total++; if (n_done !== 6) begin bad++; $display("FAIL rr_count: got %0d want 6", n_done); end
    total++; if (cpu_first !== 3) begin bad++; $display("FAIL rr_cpu_first: got %0d want 3", cpu_first); end
    total++; if (vec_first !== 7) begin bad++; $display("FAIL rr_vec_first: got %0d want 7", vec_first); end
    total++; if (both !== 1'b0) begin bad++; $display("FAIL rr_both_ready: got %b want 0", both); end
  endtask

  task automatic test_vec_write();
    xfer(1'b1, 32'h1B8, 32'hDEADBEEF, 4'b0001, 1'b0);
    total++; if (obs_lat !== 3) begin bad++; $display("FAIL vec_write_latency: got %0d want 3", obs_lat); end
    total++; if (obs_maddr !== 32'h1B8) begin bad++; $display("FAIL vec_write_addr: got %h want 000001b8", obs_maddr); end
    total++; if (obs_mwstrb !== 4'b0001) begin bad++; $display("FAIL vec_write_wstrb: got %b want 0001", obs_mwstrb); end
    total++; if (obs_mwdata !== 32'hDEADBEEF) begin bad++; $display("FAIL vec_write_wdata: got %h want deadbeef", obs_mwdata); end
    total++; if (obs_minstr !== 1'b0) begin bad++; $display("FAIL vec_write_instr: got %b want 0", obs_minstr); end
    total++; if (obs_rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL vec_write_rdata: got %h want a5a5a5a5", obs_rd); end
    total++; if (mem[110] !== 32'hA5A5A5EF) begin bad++; $display("FAIL vec_write_mem: got %h want a5a5a5ef", mem[110]); end
    total++; if (vec_mem_ready !== 1'b0) begin bad++; $display("FAIL vec_write_ready_width: got %b want 0", vec_mem_ready); end
    total++; if (obs_other !== 1'b0) begin bad++; $display("FAIL vec_write_cpu_ready: got %b want 0", obs_other); end
  endtask

  task automatic test_bus_err();
    xfer(1'b1, 32'h400, 32'h0, 4'b0000, 1'b0);
    total++; if (obs_lat !== 1) begin bad++; $display("FAIL oob_latency: got %0d want 1", obs_lat); end
    total++; if (obs_rd !== 32'h0) begin bad++; $display("FAIL oob_rdata: got %h want 0", obs_rd); end
    total++; if (obs_be !== 1'b1) begin bad++; $display("FAIL oob_bus_err: got %b want 1", obs_be); end
    total++; if (obs_mv !== 1'b0) begin bad++; $display("FAIL oob_mem_valid: got %b want 0", obs_mv); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL oob_bus_err_width: got %b want 0", bus_err); end
    xfer(1'b0, 32'hFFFFFFFC, 32'h0, 4'b0000, 1'b0);
    total++; if ({obs_lat == 1, obs_be, obs_mv} !== 3'b110) begin
      bad++; $display("FAIL oob_high_addr: got lat=%0d be=%b mv=%b want lat=1 be=1 mv=0", obs_lat, obs_be, obs_mv);
    end
    xfer(1'b0, 32'h3FC, 32'h0, 4'b0000, 1'b0);
    total++; if (obs_lat !== 3) begin bad++; $display("FAIL edge_addr_latency: got %0d want 3", obs_lat); end
    total++; if (obs_rd !== 32'h55AA55AA) begin bad++; $display("FAIL edge_addr_rdata: got %h want 55aa55aa", obs_rd); end
  endtask

  task automatic test_reset_mid();
    slave_delay = 5;
    cpu_mem_valid = 1; cpu_mem_addr = 32'h190; cpu_mem_wstrb = 0; cpu_mem_instr = 0;
    @(negedge clk);
    total++; if ({mem_valid, dbg_state} !== 3'b101) begin
      bad++; $display("FAIL mid_reset_in_req: got mem_valid=%b state=%0d want 1/1", mem_valid, dbg_state);
    end
    #2 resetn = 1'b0;
    #1;
    total++; if ({mem_valid, cpu_mem_ready, vec_mem_ready, bus_err, dbg_state} !== 6'b0) begin
      bad++; $display("FAIL mid_reset_async: got mem_valid=%b cpu_rdy=%b vec_rdy=%b state=%0d want 0",
                      mem_valid, cpu_mem_ready, vec_mem_ready, dbg_state);
    end
    cpu_mem_valid = 0;
    @(negedge clk);
    resetn = 1'b1;
    slave_delay = 1;
    @(negedge clk);
    xfer(1'b0, 32'h190, 32'h0, 4'b0000, 1'b0);
    total++; if (obs_lat !== 3) begin bad++; $display("FAIL post_reset_latency: got %0d want 3", obs_lat); end
    total++; if (obs_rd !== 32'h04030201) begin bad++; $display("FAIL post_reset_rdata: got %h want 04030201", obs_rd); end
  endtask

  task automatic test_drop();
    int mv_cnt;
    bit rdy;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL drop_pre_proto_err: got %b want 0", proto_err); end
    slave_delay = 3;
    mv_cnt = 0; rdy = 0;
    cpu_mem_valid = 1; cpu_mem_addr = 32'h190; cpu_mem_wstrb = 0; cpu_mem_instr = 0;
    @(negedge clk);
    if (mem_valid) mv_cnt++;
    cpu_mem_valid = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_valid) mv_cnt++;
      if (cpu_mem_ready) rdy = 1;
    end
    total++; if (mv_cnt !== 4) begin bad++; $display("FAIL drop_mem_valid_cycles: got %0d want 4", mv_cnt); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL drop_cpu_ready: got %b want 0", rdy); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL drop_proto_err: got %b want 1", proto_err); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL drop_back_idle: got %0d want 0", dbg_state); end
    slave_delay = 1;
    xfer(1'b0, 32'h190, 32'h0, 4'b0000, 1'b0);
    total++; if (obs_lat !== 3) begin bad++; $display("FAIL after_drop_latency: got %0d want 3", obs_lat); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_err_sticky: got %b want 1", proto_err); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h11111111;
    mem[100] = 32'h04030201;
    mem[110] = 32'hA5A5A5A5;
    mem[255] = 32'h55AA55AA;
    test_reset();
    test_cpu_read();
    test_contention();
    test_vec_write();
    test_bus_err();
    test_reset_mid();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
